// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared definitions for the 4x4 int8 matrix multiplier consumer path:
// matrix geometry constants, accumulator/index types, the drain FSM state
// encoding and the row-major flat index helper.
package matmul_pkg;

    localparam int MAT_DIM   = 4;
    localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
    localparam int DEF_ACC_W = 32;

    typedef logic signed [DEF_ACC_W-1:0] acc_t;
    typedef logic [3:0]                  idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    // Row-major position of element (m,n) inside the flattened C bus.
    function automatic idx_t flat_idx(input int m, input int n);
        return idx_t'(MAT_DIM * m + n);
    endfunction

endpackage

// File: rtl/matmul_requant.sv
// matmul_requant
// Purely combinational requantiser: arithmetic right shift of a signed
// accumulator followed by narrowing to OUT_W bits.
// Configuration macro: MATMUL_DRAIN_SAT_EN
//   defined     -> narrowing saturates to the signed OUT_W range
//   not defined -> narrowing keeps the low OUT_W bits (two's-complement wrap)
// Ports:
//   i_acc   in  ACC_W  signed accumulator value
//   o_data  out OUT_W  shifted and narrowed value
module matmul_requant #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [OUT_W-1:0] o_data
);

    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = i_acc >>> SHIFT;

`ifdef MATMUL_DRAIN_SAT_EN
    // 0111..1 shifted down leaves 2^(OUT_W-1)-1; its complement is the minimum.
    localparam logic signed [ACC_W-1:0] MAX_V =
        $signed({1'b0, {(ACC_W-1){1'b1}}}) >>> (ACC_W - OUT_W);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        o_data = w_shifted[OUT_W-1:0];
        if (w_shifted > MAX_V) begin
            o_data = MAX_V[OUT_W-1:0];
        end else if (w_shifted < MIN_V) begin
            o_data = MIN_V[OUT_W-1:0];
        end
    end
`else
    assign o_data = w_shifted[OUT_W-1:0];
`endif

endmodule

// File: rtl/matmul_result_drain.sv
// matmul_result_drain
// Consumer side of the 4x4 int8 matrix multiplier. After a launch pulse it
// waits LAT cycles, snapshots all 16 C elements, then streams them row-major
// over valid/ready, requantising each element on the way out.
// Configuration macro: MATMUL_DRAIN_SAT_EN (selects saturating narrowing
// inside matmul_requant; wrap when undefined).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   launch pulse (multiplier valid)
//   c_flat     in   C matrix, element (m,n) at [ACC_W*(4m+n) +: ACC_W]
//   out_valid  out  out_data holds an element
//   out_ready  in   downstream accepts the element
//   out_data   out  shifted and narrowed element
//   out_row    out  row index of current element
//   out_col    out  column index of current element
//   out_last   out  high with element (3,3)
//   busy       out  state is not IDLE
//   overrun    out  sticky: a start was dropped
module matmul_result_drain
    import matmul_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int ACC_W = 32,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MAT_ELEMS*ACC_W-1:0] c_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [1:0]                 out_row,
    output logic [1:0]                 out_col,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overrun
);

    localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);
    localparam idx_t       LAST_IDX = idx_t'(MAT_ELEMS - 1);

    drain_state_t     r_state;
    drain_state_t     w_next_state;
    logic [3:0]       r_lat_cnt;
    idx_t             r_idx;
    logic [ACC_W-1:0] r_snap [MAT_ELEMS];
    logic             r_overrun;

    logic             w_load_lat;
    logic             w_capture;
    logic             w_advance;
    logic             w_set_overrun;
    logic             w_is_last;
    logic [ACC_W-1:0] w_elem;

    assign w_is_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A start is only honoured in IDLE or on the cycle that retires the
    // final element; anywhere else it is dropped and flagged.
    always_comb begin
        w_next_state  = r_state;
        w_load_lat    = 1'b0;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_set_overrun = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = WAIT;
                    w_load_lat   = 1'b1;
                end
            end
            WAIT: begin
                w_set_overrun = start;
                if (r_lat_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_advance = out_ready;
                if (out_ready && w_is_last) begin
                    if (start) begin
                        w_next_state = WAIT;
                        w_load_lat   = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_set_overrun = start;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latency counter, element index, snapshot and sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt <= 4'd0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < MAT_ELEMS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            if (w_load_lat) begin
                r_lat_cnt <= LAT_LOAD;
            end else if (r_state == WAIT && r_lat_cnt != 4'd0) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end

            if (w_capture) begin
                r_idx <= '0;
                for (int m = 0; m < MAT_DIM; m++) begin
                    for (int n = 0; n < MAT_DIM; n++) begin
                        r_snap[flat_idx(m, n)] <=
                            c_flat[ACC_W*int'(flat_idx(m, n)) +: ACC_W];
                    end
                end
            end else if (w_advance) begin
                r_idx <= r_idx + idx_t'(1);
            end

            if (w_set_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_elem = r_snap[r_idx];

    matmul_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .i_acc  (w_elem),
        .o_data (out_data)
    );

    assign out_valid = (r_state == DRAIN);
    assign out_row   = r_idx[3:2];
    assign out_col   = r_idx[1:0];
    assign out_last  = (r_state == DRAIN) && w_is_last;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Consumer side of the 4x4 int8 matrix multiplier.
- Tracks the multiplier's pipeline latency after each launch, then snapshots the 16 signed 32-bit C elements at the correct cycle.
- Streams the snapshot out one element per handshake, in row-major order, over a valid/ready interface toward the writeback/DMA path.
- While draining, it applies an optional arithmetic right shift and narrows each element to the output width.

Parameters:
- LAT, 2: cycles from the launch pulse (the multiplier's valid) to C being stable; legal range 1..15.
- ACC_W, 32: width of each C element.
- OUT_W, 32: width of out_data; must be <= ACC_W.
- SHIFT, 0: arithmetic right shift applied before narrowing; legal range 0..ACC_W-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low. Asserting it (0) resets immediately; release is synchronous to clk.
- start  in  1  launch pulse; same signal that drives the multiplier's valid.
- c_flat  in  16*ACC_W  C matrix, flattened. Element (m,n) sits at bits [ACC_W*(4m+n) +: ACC_W].
- out_valid  out  1  out_data holds an element.
- out_ready  in  1  downstream accepts the element.
- out_data  out  OUT_W  shifted and narrowed element.
- out_row  out  2  row index m of the current element.
- out_col  out  2  column index n of the current element.
- out_last  out  1  high with element (3,3).
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky flag: a start was dropped.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0; state=IDLE; counters=0.
- A handshake occurs on a cycle where out_valid and out_ready are both high.
- IDLE:
  - start=1 -> WAIT, lat_cnt loaded with LAT-1.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt==0, capture all 16 elements of c_flat into a snapshot register; go to DRAIN with idx=0.
  - The capture happens exactly LAT cycles after the start edge.
- DRAIN:
  - out_valid=1 the cycle after capture. The first element is therefore available LAT+1 cycles after start.
  - out_data, out_row, out_col and out_last are driven from the register for element idx.
  - Each handshake increments idx, so the next element is presented on the following cycle with no bubbles. Full throughput is 1 element per cycle.
  - While out_valid=1 and out_ready=0, all out_* outputs hold stable.
  - The handshake on idx=15 (out_last=1) ends the drain. Next state is IDLE, or WAIT if start=1 in that same cycle (back-to-back launch accepted, no overrun).
- start in WAIT, or in DRAIN other than on the final-handshake cycle:
  - The start is ignored and overrun is set to 1.
  - overrun stays set until reset.
  - The snapshot in flight is unaffected.
- c_flat is sampled only at capture. Changes to c_flat during DRAIN have no effect.
- Arithmetic on each element:
  - Step 1: v = element >>> SHIFT (sign-preserving).
  - Step 2: narrow v to OUT_W bits, as set by the Optional Feature.
  - With OUT_W==ACC_W and SHIFT==0 the element passes through bit-exact.
- Asserting reset mid-operation discards the snapshot and all counters. out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: MATMUL_DRAIN_SAT_EN
- Defined: narrowing saturates to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Not defined: narrowing keeps the low OUT_W bits of v (two's-complement wrap).
- When OUT_W==ACC_W, both builds give identical results.

Decomposition:
- Shared package matmul_pkg holds:
  - the constants MAT_DIM=4 and MAT_ELEMS=16;
  - the typedef acc_t (signed ACC_W);
  - the typedef idx_t (4-bit element index);
  - the state enum drain_state_t {IDLE, WAIT, DRAIN};
  - a function flat_idx(m,n) returning 4m+n.
- One sub-module, matmul_requant: purely combinational shift plus narrow/saturate, built with or without MATMUL_DRAIN_SAT_EN. It is reused later by the bias/activation block.

Test Plan:
- Basic drain: LAT=2, out_ready=1, C(m,n)=100*m+n, start at cycle 0 -> out_valid rises at cycle 3. Sixteen consecutive beats 0,1,2,3,100,...,303; out_last only on 303; busy falls after the last beat.
- Backpressure: out_ready toggles 1,0,0,1... -> no element lost or duplicated. out_data/out_row/out_col stay constant across stalled cycles; same 16-value sequence as the basic drain.
- Snapshot isolation: c_flat changed to all 0x7FFFFFFF one cycle after capture -> streamed values still match the captured matrix.
- Back-to-back and overrun:
  - start asserted on the out_last handshake -> second drain begins LAT+1 cycles later; overrun=0.
  - start at beat 5 of a drain -> that start is ignored, overrun=1 and sticky.
- Narrowing: OUT_W=8, SHIFT=4, elements 0x00001000 and 0xFFFFF000.
  - With MATMUL_DRAIN_SAT_EN -> 127 and -128.
  - Without -> 0x00 and 0x00 (low 8 bits of 0x100 and -0x100).
- Reset mid-drain: rst=0 at beat 7 -> out_valid=0 immediately. After release, busy=0 and overrun=0; a new start gives a full 16-beat drain from (0,0).
